cpu_register_file: RTL and testbench
====================================

Name: cpu_register_file

Overview:
Architectural register file for the SM83 CPU core. It holds the 8-bit registers B C D E H L A F, the 16-bit SP and PC, and the internal temporary pair WZ.
- Sources both 8-bit ALU operands and the CHNZ flag nibble.
- Sinks the ALU result and output flags.
- Provides a 16-bit pair port with an inc/dec/load unit for address generation.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
RESET_SP, 16'h0000, SP value loaded on reset

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
rd_a_sel  input  4  register select for operand A (reg_sel_t)
rd_a_data  output  8  selected register, to alu_a
rd_b_sel  input  4  register select for operand B (reg_sel_t)
rd_b_data  output  8  selected register, to alu_b
flags_out  output  4  current flags CHNZ (C=bit0 … Z=bit3), to ALU flag input
wr_en  input  1  8-bit write strobe
wr_sel  input  4  8-bit write target (reg_sel_t)
wr_data  input  8  8-bit write data (ALU result or bus data)
flag_wr_en  input  1  flag write strobe
flag_in  input  4  new flags, CHNZ order
pair_sel  input  3  pair select: BC DE HL SP PC WZ (pair_sel_t)
pair_op  input  2  NONE, INC, DEC, LOAD (pair_op_t)
pair_wr_data  input  16  data for LOAD
pair_data  output  16  current value of selected pair (pre-update)

Behaviour:
- reg_sel_t encoding: B=0 C=1 D=2 E=3 H=4 L=5 F=6 A=7 SPH=8 SPL=9 PCH=10 PCL=11 W=12 Z=13. Codes 14 and 15 read 8'h00 and writes to them are ignored.
- Reads are combinational from current state; there is no write-to-read bypass. A write in cycle N is visible on reads in cycle N+1.
- Reset (synchronous): all registers 0, F=0, SP=RESET_SP, PC=RESET_PC. Outputs are combinational and follow these values from the cycle after reset. Reset asserted mid-operation discards every same-cycle write.
- F[3:0] is hard-wired 0. An 8-bit write to F stores wr_data & 8'hF0. Reading F returns {Z,N,H,C,4'b0}.
- flag_in maps to F: F[7]=flag_in[3] (Z), F[6]=flag_in[2] (N), F[5]=flag_in[1] (H), F[4]=flag_in[0] (C).
- flags_out = {F[7],F[6],F[5],F[4]}.
- 16-bit pair update, applied at the clock edge when pair_op != NONE:
  - INC: pair+1, wrapping 16'hFFFF -> 16'h0000.
  - DEC: pair-1, wrapping 16'h0000 -> 16'hFFFF.
  - LOAD: pair = pair_wr_data.
  - Pair updates never affect flags.
- pair_data always shows the pre-edge value, so it can drive the address bus while the pair post-increments in the same cycle (e.g. PC fetch).
- Pair AF is not selectable on the pair port. PUSH/POP AF uses the 8-bit port.
- Simultaneous-event priority, evaluated per byte:
  - Flag write over 8-bit write: if wr_sel=F and flag_wr_en are both active, F[7:4] takes flag_in.
  - 8-bit write over pair update: if the 8-bit write target is a byte of the pair being updated, that byte takes wr_data and the other byte takes the pair result.
  - An 8-bit write and a pair update to different registers both take effect.
- An 8-bit write to SPH/SPL/PCH/PCL/W/Z updates only that byte of the 16-bit register.
- Single-cycle: every write commits at the next rising edge; there is no multi-cycle state.

Decomposition:
- Shared package cpu_pkg holds:
  - reg_sel_t (4-bit enum above).
  - pair_sel_t: BC=0 DE=1 HL=2 SP=3 PC=4 WZ=5.
  - pair_op_t: NONE=0 INC=1 DEC=2 LOAD=3.
  - Flag index constants FLAG_C=0, FLAG_H=1, FLAG_N=2, FLAG_Z=3, shared with the ALU.
- One sub-module, incdec_16: combinational 16-bit inc/dec/pass (op, in16 -> out16). It is instantiated once here and is reusable for SP-relative addressing.

Test Plan:
- Reset with RESET_PC=16'h0100, RESET_SP=16'hFFFE -> next cycle pair PC reads 16'h0100, SP reads 16'hFFFE, all 8-bit reads 0, flags_out=0.
- Write A=8'h3C, B=8'h0F; next cycle rd_a_sel=A, rd_b_sel=B -> rd_a_data=8'h3C, rd_b_data=8'h0F. Same-cycle read during the write returns the old value 0.
- Write wr_sel=F with wr_data=8'hFF -> F reads 8'hF0, flags_out=4'hF. Same cycle also flag_wr_en with flag_in=4'b0001 -> F=8'h10, flags_out=4'b0001.
- HL=16'hFFFF, pair_op=INC -> pair_data shows 16'hFFFF that cycle; next cycle H=0, L=0. Then DEC -> 16'hFFFF. Flags unchanged throughout.
- PC=16'h1234, pair_op=INC on PC with simultaneous wr_sel=PCH, wr_data=8'hAB -> PC=16'hAB35.
- Mid-operation reset: wr_en, flag_wr_en and pair INC all active in the reset cycle -> all registers return to reset values and no write lands.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared SM83 core types: register/pair selects, pair ops, flag bit positions.
package cpu_pkg;

   typedef enum logic [3:0] {
      RegB   = 4'd0,
      RegC   = 4'd1,
      RegD   = 4'd2,
      RegE   = 4'd3,
      RegH   = 4'd4,
      RegL   = 4'd5,
      RegF   = 4'd6,
      RegA   = 4'd7,
      RegSph = 4'd8,
      RegSpl = 4'd9,
      RegPch = 4'd10,
      RegPcl = 4'd11,
      RegW   = 4'd12,
      RegZ   = 4'd13
   } reg_sel_t;

   typedef enum logic [2:0] {
      PairBc = 3'd0,
      PairDe = 3'd1,
      PairHl = 3'd2,
      PairSp = 3'd3,
      PairPc = 3'd4,
      PairWz = 3'd5
   } pair_sel_t;

   typedef enum logic [1:0] {
      PairNone = 2'd0,
      PairInc  = 2'd1,
      PairDec  = 2'd2,
      PairLoad = 2'd3
   } pair_op_t;

   localparam int unsigned NumPairs = 6;

   localparam int unsigned FLAG_C = 0;
   localparam int unsigned FLAG_H = 1;
   localparam int unsigned FLAG_N = 2;
   localparam int unsigned FLAG_Z = 3;

   // True when an 8-bit select names a byte of one of the 16-bit pairs.
   function automatic logic reg_in_pair(input logic [3:0] sel);
      return (sel < 4'd6) || ((sel >= 4'd8) && (sel <= 4'd13));
   endfunction

   // Pair index for a byte select; codes 8..13 skip the F/A slot at 6/7.
   function automatic logic [2:0] reg_pair_idx(input logic [3:0] sel);
      return sel[3] ? (sel[3:1] - 3'd1) : sel[3:1];
   endfunction

endpackage

// File: rtl/incdec_16.sv
// Combinational 16-bit increment / decrement / pass-through.
module incdec_16
   import cpu_pkg::*;
(
   input  pair_op_t    op,
   input  logic [15:0] in16,
   output logic [15:0] out16
);

   // Wrapping add/subtract; NONE and LOAD pass the input unchanged.
   always_comb begin
      out16 = in16;
      unique case (op)
         PairInc: out16 = in16 + 16'd1;
         PairDec: out16 = in16 - 16'd1;
         default: out16 = in16;
      endcase
   end

endmodule

// File: rtl/cpu_register_file.sv
// SM83 architectural register file: 8-bit operand ports, flags, 16-bit pair port.
module cpu_register_file
   import cpu_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] RESET_SP = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  rd_a_sel,
   output logic [7:0]  rd_a_data,
   input  logic [3:0]  rd_b_sel,
   output logic [7:0]  rd_b_data,
   output logic [3:0]  flags_out,
   input  logic        wr_en,
   input  logic [3:0]  wr_sel,
   input  logic [7:0]  wr_data,
   input  logic        flag_wr_en,
   input  logic [3:0]  flag_in,
   input  logic [2:0]  pair_sel,
   input  logic [1:0]  pair_op,
   input  logic [15:0] pair_wr_data,
   output logic [15:0] pair_data
);

   // BC DE HL SP PC WZ held as 16-bit words; A and the upper flag nibble apart.
   logic [15:0] pair_q [NumPairs];
   logic [15:0] pair_d [NumPairs];
   logic [7:0]  a_q, a_d;
   logic [3:0]  f_q, f_d;

   logic [7:0]  byte_view [16];
   logic [15:0] incdec_out;
   logic [15:0] pair_result;
   pair_op_t    op;

   assign op = pair_op_t'(pair_op);

   // Current value of the selected pair; unselectable codes read zero.
   always_comb begin
      pair_data = 16'h0000;
      for (int i = 0; i < NumPairs; i++) begin
         if (pair_sel == i[2:0]) pair_data = pair_q[i];
      end
   end

   incdec_16 u_incdec (
      .op    (op),
      .in16  (pair_data),
      .out16 (incdec_out)
   );

   assign pair_result = (op == PairLoad) ? pair_wr_data : incdec_out;

   // Byte view of the whole file indexed by reg_sel_t; codes 14/15 read zero.
   always_comb begin
      for (int i = 0; i < 16; i++) begin
         byte_view[i] = 8'h00;
         if (reg_in_pair(i[3:0])) begin
            for (int p = 0; p < NumPairs; p++) begin
               if (reg_pair_idx(i[3:0]) == p[2:0]) begin
                  byte_view[i] = i[0] ? pair_q[p][7:0] : pair_q[p][15:8];
               end
            end
         end
      end
      byte_view[int'(RegF)] = {f_q, 4'b0000};
      byte_view[int'(RegA)] = a_q;
   end

   assign rd_a_data = byte_view[rd_a_sel];
   assign rd_b_data = byte_view[rd_b_sel];
   assign flags_out = {f_q[FLAG_Z], f_q[FLAG_N], f_q[FLAG_H], f_q[FLAG_C]};

   // Next state: pair update, then 8-bit write over it, then flag write over F.
   always_comb begin
      a_d = a_q;
      f_d = f_q;
      for (int i = 0; i < NumPairs; i++) begin
         pair_d[i] = pair_q[i];
         if ((op != PairNone) && (pair_sel == i[2:0])) pair_d[i] = pair_result;
         if (wr_en && reg_in_pair(wr_sel) && (reg_pair_idx(wr_sel) == i[2:0])) begin
            if (wr_sel[0]) pair_d[i][7:0]  = wr_data;
            else           pair_d[i][15:8] = wr_data;
         end
      end
      if (wr_en && (wr_sel == RegA)) a_d = wr_data;
      if (wr_en && (wr_sel == RegF)) f_d = wr_data[7:4];
      if (flag_wr_en)                f_d = flag_in;
   end

   // State register with synchronous reset that overrides any same-cycle write.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NumPairs; i++) pair_q[i] <= 16'h0000;
         pair_q[int'(PairSp)] <= RESET_SP;
         pair_q[int'(PairPc)] <= RESET_PC;
         a_q <= 8'h00;
         f_q <= 4'h0;
      end else begin
         for (int i = 0; i < NumPairs; i++) pair_q[i] <= pair_d[i];
         a_q <= a_d;
         f_q <= f_d;
      end
   end

endmodule

// File: tb/tb_cpu_register_file.sv
// Self-checking bench for cpu_register_file: directed scenarios plus random vs. a byte model.
module tb_cpu_register_file;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  rd_a_sel, rd_b_sel, wr_sel, flag_in, flags_out;
   logic [7:0]  rd_a_data, rd_b_data, wr_data;
   logic        wr_en, flag_wr_en;
   logic [2:0]  pair_sel;
   logic [1:0]  pair_op;
   logic [15:0] pair_wr_data, pair_data;

   int checks = 0;
   int passed = 0;

   // Model: one byte per reg_sel code (F kept with low nibble zero).
   logic [7:0] m [16];

   cpu_register_file #(
      .RESET_PC (16'h0100),
      .RESET_SP (16'hFFFE)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rd_a_sel     (rd_a_sel),
      .rd_a_data    (rd_a_data),
      .rd_b_sel     (rd_b_sel),
      .rd_b_data    (rd_b_data),
      .flags_out    (flags_out),
      .wr_en        (wr_en),
      .wr_sel       (wr_sel),
      .wr_data      (wr_data),
      .flag_wr_en   (flag_wr_en),
      .flag_in      (flag_in),
      .pair_sel     (pair_sel),
      .pair_op      (pair_op),
      .pair_wr_data (pair_wr_data),
      .pair_data    (pair_data)
   );

   always #5 clk = ~clk;

   task automatic idle();
      reset = 0; wr_en = 0; flag_wr_en = 0; pair_op = 2'd0;
      wr_sel = 0; wr_data = 0; flag_in = 0; pair_wr_data = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int hi_code(input int p);
      case (p)
         0: return 0;
         1: return 2;
         2: return 4;
         3: return 8;
         4: return 10;
         default: return 12;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m[i] = 8'h00;
      m[8] = 8'hFF; m[9] = 8'hFE; m[10] = 8'h01; m[11] = 8'h00;
   endtask

   // Next architectural state from the current inputs, by the written rules.
   task automatic model_step();
      logic [7:0]  n [16];
      logic [15:0] v, r;
      int          h;
      for (int i = 0; i < 16; i++) n[i] = m[i];
      if (pair_op != 2'd0 && pair_sel < 3'd6) begin
         h = hi_code(int'(pair_sel));
         v = {m[h], m[h+1]};
         if (pair_op == 2'd1)      r = v + 16'd1;
         else if (pair_op == 2'd2) r = v - 16'd1;
         else                      r = pair_wr_data;
         n[h] = r[15:8]; n[h+1] = r[7:0];
      end
      if (wr_en && wr_sel < 4'd14) n[wr_sel] = (wr_sel == 4'd6) ? (wr_data & 8'hF0) : wr_data;
      if (flag_wr_en) n[6] = {flag_in, 4'b0000};
      for (int i = 0; i < 16; i++) m[i] = n[i];
      if (reset) model_reset();
   endtask

   task automatic test_reset();
      idle();
      reset = 1;
      tick();
      reset = 0;
      pair_sel = 3'd4;
      #1;
      checks++;
      if (pair_data !== 16'h0100) $display("FAIL reset_pc: got %h want %h", pair_data, 16'h0100);
      else passed++;
      pair_sel = 3'd3;
      #1;
      checks++;
      if (pair_data !== 16'hFFFE) $display("FAIL reset_sp: got %h want %h", pair_data, 16'hFFFE);
      else passed++;
      for (int i = 0; i < 16; i++) begin
         if (i >= 8 && i <= 11) continue;
         rd_a_sel = i[3:0];
         #1;
         checks++;
         if (rd_a_data !== 8'h00) $display("FAIL reset_reg%0d: got %h want 00", i, rd_a_data);
         else passed++;
      end
      checks++;
      if (flags_out !== 4'h0) $display("FAIL reset_flags: got %h want 0", flags_out);
      else passed++;
   endtask

   task automatic test_rw();
      idle();
      wr_en = 1; wr_sel = 4'd7; wr_data = 8'h3C; rd_a_sel = 4'd7;
      #1;
      checks++;
      if (rd_a_data !== 8'h00) $display("FAIL no_bypass: got %h want 00", rd_a_data);
      else passed++;
      tick();
      wr_sel = 4'd0; wr_data = 8'h0F;
      tick();
      wr_en = 0; rd_a_sel = 4'd7; rd_b_sel = 4'd0;
      #1;
      checks++;
      if (rd_a_data !== 8'h3C) $display("FAIL read_a: got %h want 3c", rd_a_data);
      else passed++;
      checks++;
      if (rd_b_data !== 8'h0F) $display("FAIL read_b: got %h want 0f", rd_b_data);
      else passed++;
   endtask

   task automatic test_flags();
      idle();
      wr_en = 1; wr_sel = 4'd6; wr_data = 8'hFF; rd_a_sel = 4'd6;
      tick();
      wr_en = 0;
      #1;
      checks++;
      if (rd_a_data !== 8'hF0) $display("FAIL f_mask: got %h want f0", rd_a_data);
      else passed++;
      checks++;
      if (flags_out !== 4'hF) $display("FAIL flags_all: got %h want f", flags_out);
      else passed++;
      wr_en = 1; flag_wr_en = 1; flag_in = 4'b0001;
      tick();
      idle();
      #1;
      checks++;
      if (rd_a_data !== 8'h10) $display("FAIL flag_prio_f: got %h want 10", rd_a_data);
      else passed++;
      checks++;
      if (flags_out !== 4'b0001) $display("FAIL flag_prio_out: got %h want 1", flags_out);
      else passed++;
   endtask

   task automatic test_pair_wrap();
      idle();
      pair_sel = 3'd2; pair_op = 2'd3; pair_wr_data = 16'hFFFF;
      tick();
      pair_op = 2'd1;
      #1;
      checks++;
      if (pair_data !== 16'hFFFF) $display("FAIL inc_pre: got %h want ffff", pair_data);
      else passed++;
      tick();
      pair_op = 2'd0; rd_a_sel = 4'd4; rd_b_sel = 4'd5;
      #1;
      checks++;
      if ({rd_a_data, rd_b_data} !== 16'h0000) $display("FAIL inc_wrap: got %h want 0000", {rd_a_data, rd_b_data});
      else passed++;
      pair_op = 2'd2;
      tick();
      pair_op = 2'd0;
      #1;
      checks++;
      if (pair_data !== 16'hFFFF) $display("FAIL dec_wrap: got %h want ffff", pair_data);
      else passed++;
      checks++;
      if (flags_out !== 4'b0001) $display("FAIL pair_flags: got %h want 1", flags_out);
      else passed++;
   endtask

   task automatic test_pc_merge();
      idle();
      pair_sel = 3'd4; pair_op = 2'd3; pair_wr_data = 16'h1234;
      tick();
      pair_op = 2'd1; wr_en = 1; wr_sel = 4'd10; wr_data = 8'hAB;
      tick();
      idle();
      #1;
      checks++;
      if (pair_data !== 16'hAB35) $display("FAIL pc_merge: got %h want ab35", pair_data);
      else passed++;
   endtask

   task automatic test_mid_reset();
      idle();
      reset = 1; wr_en = 1; wr_sel = 4'd7; wr_data = 8'h55;
      flag_wr_en = 1; flag_in = 4'hF; pair_sel = 3'd4; pair_op = 2'd1;
      tick();
      idle();
      rd_a_sel = 4'd7; rd_b_sel = 4'd4;
      #1;
      checks++;
      if (rd_a_data !== 8'h00) $display("FAIL rst_a: got %h want 00", rd_a_data);
      else passed++;
      checks++;
      if (rd_b_data !== 8'h00) $display("FAIL rst_h: got %h want 00", rd_b_data);
      else passed++;
      checks++;
      if (flags_out !== 4'h0) $display("FAIL rst_flags: got %h want 0", flags_out);
      else passed++;
      checks++;
      if (pair_data !== 16'h0100) $display("FAIL rst_pc: got %h want 0100", pair_data);
      else passed++;
   endtask

   task automatic test_random();
      logic [15:0] exp_pair;
      int          h;
      idle();
      reset = 1;
      tick();
      model_reset();
      for (int k = 0; k < 400; k++) begin
         reset        = ($urandom_range(0, 49) == 0);
         rd_a_sel     = 4'($urandom_range(0, 15));
         rd_b_sel     = 4'($urandom_range(0, 15));
         wr_en        = 1'($urandom_range(0, 1));
         wr_sel       = 4'($urandom_range(0, 15));
         wr_data      = 8'($urandom);
         flag_wr_en   = ($urandom_range(0, 3) == 0);
         flag_in      = 4'($urandom);
         pair_sel     = 3'($urandom_range(0, 5));
         pair_op      = 2'($urandom_range(0, 3));
         pair_wr_data = 16'($urandom);
         #1;
         h = hi_code(int'(pair_sel));
         exp_pair = {m[h], m[h+1]};
         checks++;
         if (rd_a_data !== ((rd_a_sel < 4'd14) ? m[rd_a_sel] : 8'h00))
            $display("FAIL rnd_rd_a[%0d]: got %h want %h", k, rd_a_data,
                     (rd_a_sel < 4'd14) ? m[rd_a_sel] : 8'h00);
         else passed++;
         checks++;
         if (rd_b_data !== ((rd_b_sel < 4'd14) ? m[rd_b_sel] : 8'h00))
            $display("FAIL rnd_rd_b[%0d]: got %h want %h", k, rd_b_data,
                     (rd_b_sel < 4'd14) ? m[rd_b_sel] : 8'h00);
         else passed++;
         checks++;
         if (flags_out !== m[6][7:4]) $display("FAIL rnd_flags[%0d]: got %h want %h", k, flags_out, m[6][7:4]);
         else passed++;
         checks++;
         if (pair_data !== exp_pair) $display("FAIL rnd_pair[%0d]: got %h want %h", k, pair_data, exp_pair);
         else passed++;
         model_step();
         tick();
      end
      idle();
   endtask

   initial begin
      rd_a_sel = 0; rd_b_sel = 0; pair_sel = 0;
      idle();
      tick();
      test_reset();
      test_rw();
      test_flags();
      test_pair_wrap();
      test_pc_merge();
      test_mid_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
